// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the program loader: the loader FSM state type and the
// default frame constants used as parameter defaults by program_loader.
// -----------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        CSUM  = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } loader_state_t;

    localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;
    localparam int         LOADER_MAX_WORDS = 64;

endpackage

// File: rtl/word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Packs little-endian bytes into 32-bit words. Each accepted byte lands in the
// lane given by a 2-bit counter; on the fourth byte the completed word is
// captured into word_o and word_valid_o pulses for one cycle afterwards.
// word_o holds its value until the next word completes.
//
// Ports:
//   clk           system clock
//   reset_i       asynchronous active-high reset
//   clear_i       restart packing at lane 0 (start of a new frame body)
//   byte_en_i     byte_i is consumed this cycle
//   byte_i        incoming byte
//   word_done_o   combinational: this cycle's byte completes a word
//   word_valid_o  registered one-cycle pulse after a word completes
//   word_o        last completed word
// -----------------------------------------------------------------------------
module word_assembler (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic        word_done_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  lane_q,  lane_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] word_q,  word_d;
    logic        valid_q, valid_d;

    assign word_done_o = byte_en_i && (lane_q == 2'd3);

    always_comb begin
        lane_d  = lane_q;
        shift_d = shift_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (clear_i) begin
            lane_d = 2'd0;
        end else if (byte_en_i) begin
            shift_d[8*lane_q +: 8] = byte_i;
            lane_d = lane_q + 2'd1;
            // Capture from shift_d so the fourth byte is included without
            // waiting for it to land in shift_q.
            if (lane_q == 2'd3) begin
                word_d  = shift_d;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            lane_q  <= 2'd0;
            shift_q <= 32'd0;
            word_q  <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            lane_q  <= lane_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word_valid_o = valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Writer side of the instruction-fetch path. Parses a framed byte stream
// (SYNC_BYTE, LEN, 4*LEN little-endian data bytes[, checksum]) and writes the
// packed words to program memory at byte addresses 0, 4, 8, ... The core is
// held in reset until the whole image has been written and accepted.
//
// Build option: define LOADER_CHECKSUM_EN to expect a trailing checksum byte
// (XOR of all data bytes). Without it the image is accepted right after the
// last data word and only a bad LEN leads to ERROR.
//
// Ports:
//   clk           system clock
//   reset_i       asynchronous active-high reset
//   byte_valid_i  byte_data_i valid
//   byte_data_i   stream byte
//   byte_ready_o  loader can accept a byte
//   restart_i     pulse: DONE/ERROR -> IDLE
//   pm_we_o       program-memory write strobe (one cycle)
//   pm_addr_o     word-aligned byte address
//   pm_wdata_o    word to write
//   core_reset_o  core reset, released once the image is complete
//   done_o        image loaded, core running
//   error_o       frame rejected
// -----------------------------------------------------------------------------
module program_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W    = 8,
    parameter int         MAX_WORDS = LOADER_MAX_WORDS,
    parameter logic [7:0] SYNC_BYTE = LOADER_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    input  logic              restart_i,
    output logic              pm_we_o,
    output logic [ADDR_W-1:0] pm_addr_o,
    output logic [31:0]       pm_wdata_o,
    output logic              core_reset_o,
    output logic              done_o,
    output logic              error_o
);

    loader_state_t state_q, state_d;

    logic [7:0]        len_q,  len_d;
    logic [7:0]        idx_q,  idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic accept;
    logic len_bad;
    logic len_en;
    logic data_en;
    logic word_done;
    logic word_last;
    logic word_valid;
    logic [31:0] word;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
`endif

    assign accept    = byte_valid_i && byte_ready_o;
    assign len_bad   = (byte_data_i == 8'd0) || (int'(byte_data_i) > MAX_WORDS);
    assign len_en    = accept && (state_q == LEN) && !len_bad;
    assign data_en   = accept && (state_q == DATA);
    assign word_last = word_done && (idx_q == len_q - 8'd1);

    word_assembler u_asm (
        .clk          (clk),
        .reset_i      (reset_i),
        .clear_i      (len_en),
        .byte_en_i    (data_en),
        .byte_i       (byte_data_i),
        .word_done_o  (word_done),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    // State register
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && byte_data_i == SYNC_BYTE) state_d = LEN;
            end
            LEN: begin
                if (accept) state_d = len_bad ? ERROR : DATA;
            end
            DATA: begin
`ifdef LOADER_CHECKSUM_EN
                if (word_last) state_d = CSUM;
`else
                // The final write strobe coincides with the first DONE cycle,
                // so the core never leaves reset ahead of its last word.
                if (word_last) state_d = DONE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept) state_d = (byte_data_i == csum_q) ? DONE : ERROR;
            end
`endif
            DONE, ERROR: begin
                if (restart_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        byte_ready_o = 1'b1;
        core_reset_o = 1'b1;
        done_o       = 1'b0;
        error_o      = 1'b0;
        case (state_q)
            DONE: begin
                byte_ready_o = 1'b0;
                core_reset_o = 1'b0;
                done_o       = 1'b1;
            end
            ERROR: begin
                byte_ready_o = 1'b0;
                error_o      = 1'b1;
            end
            default: ;
        endcase
    end

    // Frame bookkeeping: length, word index, write address, running checksum
    always_comb begin
        len_d  = len_q;
        idx_d  = idx_q;
        addr_d = addr_q;
        if (len_en) begin
            len_d = byte_data_i;
            idx_d = 8'd0;
        end else if (word_done) begin
            addr_d = ADDR_W'({idx_q, 2'b00});
            idx_d  = idx_q + 8'd1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_comb begin
        csum_d = csum_q;
        if (len_en) begin
            csum_d = 8'd0;
        end else if (data_en) begin
            csum_d = csum_q ^ byte_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            csum_q <= 8'd0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            len_q  <= 8'd0;
            idx_q  <= 8'd0;
            addr_q <= '0;
        end else begin
            len_q  <= len_d;
            idx_q  <= idx_d;
            addr_q <= addr_d;
        end
    end

    assign pm_we_o    = word_valid;
    assign pm_addr_o  = addr_q;
    assign pm_wdata_o = word;

endmodule
